rr_decoder_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 3:8-decoded resource between 8 requesters.

---
 rtl/rr_decoder_arbiter.sv | 103 ++++++++++
 tb/tb_rr_decoder_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for one shared 3:8-decoded resource with 8 requesters.
// Optional forced release after MAX_HOLD+1 grant cycles when ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  input  logic       rel_i,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_en_o,
  output logic [7:0] gnt_o,
  output logic       busy_o,
  output logic       tmo_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e     state_q;
  logic [2:0] ptr_q, gnt_idx_q;
  logic       gnt_en_q, tmo_q;

  logic [2:0] win, cand;
  logic       found, expire, owner_req, release_c;

  // First requester at or after ptr_q, wrapping through all 8 positions.
  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign owner_req = req_i[gnt_idx_q];
  assign release_c = rel_i || !owner_req || expire;

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] hold_q;
  assign expire = (hold_q == CW'(MAX_HOLD));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (state_q == IDLE) begin
      if (found) hold_q <= '0;
    end else begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CW'(MAX_HOLD)};
  assign expire     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      gnt_idx_q <= 3'd0;
      gnt_en_q  <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q   <= BUSY;
            gnt_idx_q <= win;
            gnt_en_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (release_c) begin
            state_q  <= IDLE;
            gnt_en_q <= 1'b0;
            ptr_q    <= gnt_idx_q + 3'd1;
            // A voluntary release (rel or withdrawal) in the same cycle masks the timeout flag.
            tmo_q    <= expire && !rel_i && owner_req;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    assign gnt_o[g] = gnt_en_q && (gnt_idx_q == 3'(g));
  end

  assign gnt_idx_o = gnt_idx_q;
  assign gnt_en_o  = gnt_en_q;
  assign busy_o    = (state_q == BUSY);
  assign tmo_o     = tmo_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an owner/pointer reference model.
module tb_rr_decoder_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'hFF;
  logic       rel = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_en, busy, tmo;
  logic [7:0] gnt;

  int errors = 0;
  int checks = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rel_i(rel),
    .gnt_idx_o(gnt_idx), .gnt_en_o(gnt_en), .gnt_o(gnt), .busy_o(busy), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the grant.
  int owner = -1;
  int ptr = 0;
  int hold = 0;
  int last_idx = 0;
  bit tmo_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; ptr = 0; hold = 0; last_idx = 0; tmo_m = 1'b0;
    end else begin
      tmo_m = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < 8; k++) begin
          if (owner < 0 && req[(ptr + k) % 8]) begin
            owner = (ptr + k) % 8;
            last_idx = owner;
            hold = 0;
          end
        end
      end else if (rel || !req[owner] || (TMO && hold == MAX_HOLD)) begin
        tmo_m = TMO && hold == MAX_HOLD && !rel && req[owner];
        ptr = (owner + 1) % 8;
        owner = -1;
      end else begin
        hold++;
      end
    end
  end

  always @(negedge clk) begin
    check("gnt_idx", 32'(gnt_idx), 32'(last_idx));
    check("gnt_en", 32'(gnt_en), 32'(owner >= 0));
    check("gnt", 32'(gnt), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    check("busy", 32'(busy), 32'(owner >= 0));
    check("tmo", 32'(tmo), 32'(tmo_m));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int held;
  bit seen_tmo;

  initial begin
    // Reset with all requesting
    tick(3);
    check("rst_gnt_en", 32'(gnt_en), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("first_idx", 32'(gnt_idx), 32'd0);
    check("first_en", 32'(gnt_en), 32'd1);

    // Rotation 0..7 and wrap to 0, one idle cycle between grants
    for (int g = 1; g <= 9; g++) begin
      rel = 1'b1; tick(1);
      check("rot_gap", 32'(gnt_en), 32'd0);
      rel = 1'b0; tick(1);
      check("rot_idx", 32'(gnt_idx), 32'(g % 8));
      check("rot_en", 32'(gnt_en), 32'd1);
    end

    // Single requester 5
    rel = 1'b1; req = 8'h20; tick(1);
    rel = 1'b0; tick(1);
    check("single_idx", 32'(gnt_idx), 32'd5);
    check("single_gnt", 32'(gnt), 32'h20);
    rel = 1'b1; tick(1);
    check("single_rel", 32'(gnt), 32'h00);
    rel = 1'b0; req = 8'h00; tick(1);

    // Priority: owner 6 released -> ptr 7 -> 0 beats 6
    req = 8'h40; tick(1);
    check("prio_own6", 32'(gnt_idx), 32'd6);
    rel = 1'b1; tick(1);
    rel = 1'b0; req = 8'h41; tick(1);
    check("prio_idx", 32'(gnt_idx), 32'd0);
    check("prio_gnt", 32'(gnt), 32'h01);

    // Withdraw by owner 3
    rel = 1'b1; tick(1);
    rel = 1'b0; req = 8'h00; tick(1);
    req = 8'h08; tick(1);
    check("wd_idx", 32'(gnt_idx), 32'd3);
    req = 8'h00; tick(1);
    check("wd_rel", 32'(gnt_en), 32'd0);

    // Asynchronous reset mid-grant clears immediately and resets ptr
    req = 8'h08; tick(1);
    check("mid_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    tick(1);
    rst_n = 1'b1; req = 8'hFF; tick(1);
    check("rst_ptr0", 32'(gnt_idx), 32'd0);

    // Hold length / timeout with a silent owner 2 (bounded loop)
    rel = 1'b1; tick(1);
    rel = 1'b0; req = 8'h00; tick(1);
    req = 8'h04; tick(1);
    held = gnt_en ? 1 : 0;
    seen_tmo = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (gnt_en) held++;
      else begin
        seen_tmo = tmo;
        break;
      end
    end
    check("hold_len", 32'(held), TMO ? 32'd16 : 32'd41);
    check("tmo_seen", 32'(seen_tmo), 32'(TMO));

    // Randomized traffic with rare resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) req = 8'h00;
      rel = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end

    // Long no-release stretches with everyone requesting
    req = 8'hFF; rel = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 40) == 0) rel = 1'b1;
      tick(1);
      rel = 1'b0;
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
